// File: rtl/inst_rom_resp_pkg.sv
// Shared types and constants for the instruction ROM responder.
// Fetch enable encodings, NOP word, FSM state codes.
package inst_rom_resp_pkg;

    localparam int unsigned INST_W = 32;

    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;

    localparam logic [INST_W-1:0] ZERO_WORD = 32'h0000_0000;
    localparam logic [INST_W-1:0] NOP_WORD  = 32'h0000_0000;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_WAIT = 1'b1
    } state_e;

endpackage

// File: rtl/inst_rom_resp_mem.sv
// Word-addressed instruction store: sync write, sync read, read-before-write.
// Ports: clk_i, wr_en_i/wr_idx_i/wr_data_i, rd_en_i/rd_idx_i, rd_data_o (holds when !rd_en_i).
module inst_mem_array
    import inst_rom_resp_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic              clk_i,
    input  logic              wr_en_i,
    input  logic [ADDR_W-1:0] wr_idx_i,
    input  logic [INST_W-1:0] wr_data_i,
    input  logic              rd_en_i,
    input  logic [ADDR_W-1:0] rd_idx_i,
    output logic [INST_W-1:0] rd_data_o
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [INST_W-1:0] mem_q [DEPTH];
    logic [INST_W-1:0] rd_data_q;

    // Both in one block: the read samples the pre-edge contents,
    // so a same-edge write to the same word is seen one fetch later.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_idx_i] <= wr_data_i;
        end
        if (rd_en_i) begin
            rd_data_q <= mem_q[rd_idx_i];
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/inst_rom_resp.sv
// Fetch responder: PC address in, instruction word out, optional wait states.
// Ports: clk, clr, ce, addr, flush, wr_en/wr_addr/wr_data -> inst, inst_valid, stallreq.
module inst_rom_resp
    import inst_rom_resp_pkg::*;
#(
    parameter int               ADDR_W      = 10,
    parameter int               WAIT_CYCLES = 0,
    parameter logic [INST_W-1:0] NOP_INST   = NOP_WORD
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              ce,
    input  logic [31:0]       addr,
    input  logic              flush,
    input  logic              wr_en,
    input  logic [31:0]       wr_addr,
    input  logic [31:0]       wr_data,
    output logic [INST_W-1:0] inst,
    output logic              inst_valid,
    output logic              stallreq
);

    localparam bit HAS_WAIT = (WAIT_CYCLES > 0);
    localparam int CNT_W    = HAS_WAIT ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD =
        CNT_W'(HAS_WAIT ? WAIT_CYCLES - 1 : 0);

    state_e            state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [ADDR_W-1:0] idx_q;
    logic              valid_q;

    logic [ADDR_W-1:0] fetch_idx;
    logic [ADDR_W-1:0] wr_idx;
    logic              go;
    logic              rd_en_d;
    logic [ADDR_W-1:0] rd_idx_d;
    logic [INST_W-1:0] rd_data;

    assign fetch_idx = addr[ADDR_W+1:2];
    assign wr_idx    = wr_addr[ADDR_W+1:2];

    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr[31:ADDR_W+2], addr[1:0],
                                wr_addr[31:ADDR_W+2], wr_addr[1:0]};

    // A dropped ce behaves exactly like a flush.
    assign go = (ce == CHIP_ENABLE) && !flush;

    always_comb begin
        rd_en_d  = 1'b0;
        rd_idx_d = idx_q;
        if (!clr && go) begin
            if (!HAS_WAIT) begin
                rd_en_d  = (state_q == ST_IDLE);
                rd_idx_d = fetch_idx;
            end else begin
                rd_en_d  = (state_q == ST_WAIT) && (cnt_q == '0);
            end
        end
    end

    // Stall covers the accept cycle and every WAIT cycle but the last,
    // so the PC is held for exactly WAIT_CYCLES edges.
    always_comb begin
        stallreq = 1'b0;
        if (!clr && go) begin
            unique case (state_q)
                ST_IDLE: stallreq = HAS_WAIT;
                ST_WAIT: stallreq = (cnt_q != '0);
                default: stallreq = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (go && HAS_WAIT) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= CNT_LOAD;
                        idx_q   <= fetch_idx;
                        valid_q <= 1'b0;
                    end else begin
                        valid_q <= go;
                    end
                end
                ST_WAIT: begin
                    if (!go) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b0;
                    end else if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                        valid_q <= 1'b1;
                    end else begin
                        cnt_q   <= cnt_q - CNT_W'(1);
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    inst_mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i     (clk),
        .wr_en_i   (wr_en),
        .wr_idx_i  (wr_idx),
        .wr_data_i (wr_data),
        .rd_en_i   (rd_en_d),
        .rd_idx_i  (rd_idx_d),
        .rd_data_o (rd_data)
    );

    // Both mux inputs are registers, so inst is a clean registered value.
    assign inst       = valid_q ? rd_data : NOP_INST;
    assign inst_valid = valid_q;

endmodule
